// File: rtl/mc_pkg.sv
// Shared constants and state encoding for the operand-RAM initiator (mem_controller).
package mc_pkg;

  localparam int MC_ADDR_W = 6;
  localparam int MC_DATA_W = 128;
  localparam int MC_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mc_stream_if.sv
// Operand-pair valid/ready stream with last flag; master produces, slave consumes.
interface mc_stream_if #(
  parameter int DATA_W = mc_pkg::MC_DATA_W
);
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  modport master (output valid, last, opa, opb, input ready);
  modport slave  (input valid, last, opa, opb, output ready);
endinterface

// File: rtl/mc_out_stage.sv
// Valid/ready output register for operand pairs; 1-cycle load-to-valid latency.
// Loads only when empty or draining (load_en), so contents hold while stalled.
module mc_out_stage
  import mc_pkg::*;
#(
  parameter int DATA_W = MC_DATA_W
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  input  logic              in_last,
  output logic              load_en,
  mc_stream_if.master       op
);

  assign load_en = !op.valid || op.ready;

  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      op.valid <= 1'b0;
      op.last  <= 1'b0;
      op.opa   <= '0;
      op.opb   <= '0;
    end else if (load_en) begin
      op.valid <= load;
      if (load) begin
        op.opa  <= in_opa;
        op.opb  <= in_opb;
        op.last <= in_last;
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Fills the dual-operand RAM from host writes, then streams entries out on host_start.
// Optional MC_KEEP_EN: completion keeps the buffer so a later start replays it.
module mem_controller
  import mc_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W,
  parameter int DEPTH  = MC_DEPTH
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [DATA_W-1:0] host_data_opa,
  input  logic [DATA_W-1:0] host_data_opb,
  input  logic              host_start,
  output logic [ADDR_W-1:0] mc_address_mem_opa,
  output logic [ADDR_W-1:0] mc_address_mem_opb,
  output logic              mc_mem_we,
  output logic [DATA_W-1:0] mc_data_in_opa,
  output logic [DATA_W-1:0] mc_data_in_opb,
  input  logic [DATA_W-1:0] mem_data_out_opa,
  input  logic [DATA_W-1:0] mem_data_out_opb,
  mc_stream_if.master       op,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              mc_error
);

  localparam int FILL_W = ADDR_W + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  mc_state_e         state;
  logic [FILL_W-1:0] fill;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic [FILL_W-1:0] fill_post;
  logic              load_en;
  logic              load;
  logic              last_ent;

  assign host_wr_ready = (state == IDLE) && (fill < FULL);
  assign wr_acc        = host_wr_valid && host_wr_ready;
  assign fill_post     = fill + FILL_W'(wr_acc);

  assign mc_mem_we      = wr_acc;
  assign mc_data_in_opa = host_data_opa;
  assign mc_data_in_opb = host_data_opb;

  assign mc_address_mem_opa = (state == STREAM) ? rd_ptr : wr_ptr;
  assign mc_address_mem_opb = (state == STREAM) ? rd_ptr : wr_ptr;

  assign load     = (state == STREAM) && load_en;
  assign last_ent = ({1'b0, rd_ptr} == (fill - FILL_W'(1)));

  mc_out_stage #(.DATA_W(DATA_W)) u_out (
    .mc_clk   (mc_clk),
    .mc_reset (mc_reset),
    .load     (load),
    .in_opa   (mem_data_out_opa),
    .in_opb   (mem_data_out_opb),
    .in_last  (last_ent),
    .load_en  (load_en),
    .op       (op)
  );

  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      state    <= IDLE;
      fill     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mc_busy  <= 1'b0;
      mc_done  <= 1'b0;
      mc_error <= 1'b0;
    end else begin
      mc_done  <= 1'b0;
      mc_error <= 1'b0;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        fill   <= fill + FILL_W'(1);
      end
      case (state)
        IDLE: begin
          // A write in the same cycle counts toward the start decision.
          if (host_start) begin
            if (fill_post != '0) begin
              state   <= STREAM;
              mc_busy <= 1'b1;
            end else begin
              mc_error <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (load) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (last_ent) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (op.ready) begin
            state   <= DONE;
            mc_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          mc_busy <= 1'b0;
          rd_ptr  <= '0;
`ifdef MC_KEEP_EN
`else
          fill    <= '0;
          wr_ptr  <= '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed + randomized bench for mem_controller against a queue-based model of stored pairs.
module tb_mem_controller;
  import mc_pkg::*;

  typedef struct packed {
    logic [MC_DATA_W-1:0] a;
    logic [MC_DATA_W-1:0] b;
  } pair_t;

  logic                 mc_clk = 1'b0;
  logic                 mc_reset = 1'b1;
  logic                 host_wr_valid = 1'b0;
  logic                 host_wr_ready;
  logic [MC_DATA_W-1:0] host_data_opa = '0;
  logic [MC_DATA_W-1:0] host_data_opb = '0;
  logic                 host_start = 1'b0;
  logic [MC_ADDR_W-1:0] mc_address_mem_opa;
  logic [MC_ADDR_W-1:0] mc_address_mem_opb;
  logic                 mc_mem_we;
  logic [MC_DATA_W-1:0] mc_data_in_opa;
  logic [MC_DATA_W-1:0] mc_data_in_opb;
  logic [MC_DATA_W-1:0] mem_data_out_opa;
  logic [MC_DATA_W-1:0] mem_data_out_opb;
  logic                 mc_busy;
  logic                 mc_done;
  logic                 mc_error;

  int    vectors = 0;
  int    miscompares = 0;
  pair_t stored[$];

  always #5 mc_clk = ~mc_clk;

  mc_stream_if op_if ();

  mem_controller dut (
    .mc_clk             (mc_clk),
    .mc_reset           (mc_reset),
    .host_wr_valid      (host_wr_valid),
    .host_wr_ready      (host_wr_ready),
    .host_data_opa      (host_data_opa),
    .host_data_opb      (host_data_opb),
    .host_start         (host_start),
    .mc_address_mem_opa (mc_address_mem_opa),
    .mc_address_mem_opb (mc_address_mem_opb),
    .mc_mem_we          (mc_mem_we),
    .mc_data_in_opa     (mc_data_in_opa),
    .mc_data_in_opb     (mc_data_in_opb),
    .mem_data_out_opa   (mem_data_out_opa),
    .mem_data_out_opb   (mem_data_out_opb),
    .op                 (op_if),
    .mc_busy            (mc_busy),
    .mc_done            (mc_done),
    .mc_error           (mc_error)
  );

  // Behavioural single-port RAM with combinational read.
  logic [MC_DATA_W-1:0] ram_a [MC_DEPTH];
  logic [MC_DATA_W-1:0] ram_b [MC_DEPTH];
  always @(posedge mc_clk) begin
    if (mc_mem_we) begin
      ram_a[mc_address_mem_opa] <= mc_data_in_opa;
      ram_b[mc_address_mem_opa] <= mc_data_in_opb;
    end
  end
  assign mem_data_out_opa = ram_a[mc_address_mem_opa];
  assign mem_data_out_opb = ram_b[mc_address_mem_opb];

  task automatic chk(input string tag, input logic [MC_DATA_W-1:0] obs, input logic [MC_DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic do_reset();
    mc_reset      = 1'b1;
    host_wr_valid = 1'b0;
    host_start    = 1'b0;
    op_if.ready   = 1'b0;
    tick();
    tick();
    mc_reset = 1'b0;
    stored.delete();
  endtask

  function automatic logic [MC_DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_pair(input logic [MC_DATA_W-1:0] a, input logic [MC_DATA_W-1:0] b);
    bit acc;
    host_wr_valid = 1'b1;
    host_data_opa = a;
    host_data_opb = b;
    #1;
    acc = stored.size() < MC_DEPTH;
    chk("wr_ready", host_wr_ready, acc);
    chk("mem_we", mc_mem_we, acc);
    if (acc) chk("wr_addr", mc_address_mem_opa, stored.size());
    tick();
    host_wr_valid = 1'b0;
    if (acc) stored.push_back('{a: a, b: b});
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic start_and_check(input int mode, input bit with_wr);
    pair_t            exp_q[$];
    bit               pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit               rdy, prev_stall, finished;
    pair_t            held;
    logic             held_last;
    int               n, cyc;
    logic [MC_DATA_W-1:0] a, b;
    a = rnd128();
    b = rnd128();
    host_start = 1'b1;
    if (with_wr) begin
      host_wr_valid = 1'b1;
      host_data_opa = a;
      host_data_opb = b;
    end
    tick();
    host_start    = 1'b0;
    host_wr_valid = 1'b0;
    if (with_wr) stored.push_back('{a: a, b: b});
    exp_q = stored;
    n = exp_q.size();
    if (n == 0) begin
      chk("err_pulse", mc_error, 1'b1);
      chk("err_busy", mc_busy, 1'b0);
      chk("err_valid", op_if.valid, 1'b0);
      tick();
      chk("err_clear", mc_error, 1'b0);
      chk("err_valid2", op_if.valid, 1'b0);
      return;
    end
    chk("start_busy", mc_busy, 1'b1);
    chk("start_valid", op_if.valid, 1'b0);
    prev_stall = 1'b0;
    finished   = 1'b0;
    held       = '0;
    held_last  = 1'b0;
    cyc        = 0;
    while (cyc < 2000 && !finished) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      op_if.ready = rdy;
      if (prev_stall) begin
        chk("hold_opa", op_if.opa, held.a);
        chk("hold_opb", op_if.opb, held.b);
        chk("hold_last", op_if.last, held_last);
      end
      if (op_if.valid && rdy) begin
        chk("op_opa", op_if.opa, exp_q[0].a);
        chk("op_opb", op_if.opb, exp_q[0].b);
        chk("op_last", op_if.last, exp_q.size() == 1);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) finished = 1'b1;
      end
      prev_stall = op_if.valid && !rdy;
      held       = '{a: op_if.opa, b: op_if.opb};
      held_last  = op_if.last;
      tick();
      cyc++;
    end
    op_if.ready = 1'b0;
    if (!finished) begin
      chk("stream_timeout", 1'b0, 1'b1);
      return;
    end
    if (mode == 0) chk("stream_cycles", cyc, n + 1);
    chk("done_pulse", mc_done, 1'b1);
    chk("done_valid", op_if.valid, 1'b0);
    tick();
    chk("done_clear", mc_done, 1'b0);
    chk("idle_busy", mc_busy, 1'b0);
`ifndef MC_KEEP_EN
    stored.delete();
`endif
  endtask

  initial begin
    op_if.ready = 1'b0;
    do_reset();
    chk("rst_valid", op_if.valid, 1'b0);
    chk("rst_last", op_if.last, 1'b0);
    chk("rst_opa", op_if.opa, '0);
    chk("rst_opb", op_if.opb, '0);
    chk("rst_done", mc_done, 1'b0);
    chk("rst_error", mc_error, 1'b0);
    chk("rst_busy", mc_busy, 1'b0);
    chk("rst_wr_ready", host_wr_ready, 1'b1);

    // Three known pairs, full-rate consumer.
    write_pair(128'd1, 128'h10);
    write_pair(128'd2, 128'h20);
    write_pair(128'd3, 128'h30);
    start_and_check(0, 1'b0);

    // Same pairs with a stalling consumer.
    do_reset();
    write_pair(128'd1, 128'h10);
    write_pair(128'd2, 128'h20);
    write_pair(128'd3, 128'h30);
    start_and_check(1, 1'b0);

    // Fill to capacity; the 65th write must be refused.
    do_reset();
    for (int i = 0; i < MC_DEPTH + 1; i++) write_pair(rnd128(), rnd128());
    start_and_check(2, 1'b0);

    // Start on an empty buffer.
    do_reset();
    start_and_check(0, 1'b0);

    // Write coinciding with start.
    do_reset();
    write_pair(rnd128(), rnd128());
    start_and_check(2, 1'b1);

    // Random fills with random backpressure.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) write_pair(rnd128(), rnd128());
      start_and_check(2, 1'b0);
    end

    // Reset mid-stream with the consumer stalled.
    do_reset();
    for (int i = 0; i < 3; i++) write_pair(rnd128(), rnd128());
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    tick();
    chk("stall_valid", op_if.valid, 1'b1);
    mc_reset = 1'b1;
    tick();
    chk("midrst_valid", op_if.valid, 1'b0);
    chk("midrst_busy", mc_busy, 1'b0);
    chk("midrst_wr_ready", host_wr_ready, 1'b1);
    mc_reset = 1'b0;
    stored.delete();
    write_pair(rnd128(), rnd128());
    start_and_check(2, 1'b0);
    // Restart after completion: replay when kept, error when emptied.
    start_and_check(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
